nonce_report_arbiter: RTL and testbench

- Shares the single best-nonce recorder between NUM_CORES hashing cores.
- Round-robin grants one core at a time and drives the recorder's fixed 14-cycle save protocol on main_bus_o: select + core ID, bits-off, 3 hold cycles, 8 nonce words.
- Also sequences "reset best" clear requests so they never collide with a save in flight.

---
 rtl/nonce_report_arbiter.sv | 137 +++++++++++++
 tb/tb_nonce_report_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_report_arbiter.sv
// Round-robin arbiter sharing one best-nonce recorder between hashing cores.
// Drives the recorder's fixed save sequence and slots clear requests between saves.
module nonce_report_arbiter #(
    parameter int          NUM_CORES    = 4,
    parameter logic [23:0] CORE_ID_BASE = 24'h000000,
    parameter int          NONCE_WORDS  = 8,
    parameter int          HOLD_CYCLES  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CORES-1:0]    req_i,
    input  logic [NUM_CORES*16-1:0] bits_off_i,
    input  logic [NUM_CORES*16-1:0] nonce_word_i,
    output logic [2:0]              nonce_word_sel_o,
    output logic [NUM_CORES-1:0]    grant_o,
    output logic [NUM_CORES-1:0]    ack_o,
    input  logic                    clear_best_i,
    output logic                    busy_o,
    output logic [23:0]             main_bus_o,
    output logic                    save_selection_o,
    output logic                    reset_best_nonce_o
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = 4;
    localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, SELECT, BITS, HOLD, NONCE, DONE
    } state_t;

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gidx;
    logic [NUM_CORES-1:0] grant;
    logic [CW-1:0]        cnt;
    logic                 clear_pending;

    logic                 found;
    logic [IW-1:0]        pick;
    int                   idx;

    // First requester strictly after the last grantee, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            idx = (int'(ptr) + i) % NUM_CORES;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ptr           <= IW'(NUM_CORES - 1);
            gidx          <= '0;
            grant         <= '0;
            cnt           <= '0;
            clear_pending <= 1'b0;
        end else begin
            if (state == CLEAR)
                clear_pending <= 1'b0;
            else if (clear_best_i)
                clear_pending <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (clear_pending || clear_best_i) begin
                        state <= CLEAR;
                    end else if (found) begin
                        state <= SELECT;
                        gidx  <= pick;
                        ptr   <= pick;
                        grant <= ONE << pick;
                    end
                end
                CLEAR:  state <= IDLE;
                SELECT: state <= BITS;
                BITS: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state <= NONCE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NONCE: begin
                    if (cnt == CW'(NONCE_WORDS - 1))
                        state <= DONE;
                    else
                        cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Nonce data passes straight through so the word matches its select.
    always_comb begin
        main_bus_o         = '0;
        save_selection_o   = 1'b0;
        reset_best_nonce_o = 1'b0;
        nonce_word_sel_o   = '0;
        ack_o              = '0;
        unique case (state)
            CLEAR: reset_best_nonce_o = 1'b1;
            SELECT: begin
                save_selection_o = 1'b1;
                main_bus_o       = CORE_ID_BASE + 24'(gidx);
            end
            BITS: main_bus_o = {8'd0, bits_off_i[int'(gidx)*16 +: 16]};
            NONCE: begin
                nonce_word_sel_o = cnt[2:0];
                main_bus_o       = {8'd0, nonce_word_i[int'(gidx)*16 +: 16]};
            end
            DONE: ack_o = grant;
            default: ;
        endcase
    end

    assign grant_o = grant;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_nonce_report_arbiter.sv
// Bench for nonce_report_arbiter: per-cycle expected recorder traffic
// is queued as stimulus is applied and popped at each falling edge.
module tb_nonce_report_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic        ss;
        logic        rb;
        logic        busy;
        logic [23:0] bus;
        logic [2:0]  sel;
        logic [N-1:0] grant;
        logic [N-1:0] ack;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic           clear_best = 1'b0;
    logic [N*16-1:0] bits_off, nw_a, nw_b;
    logic [2:0]     sel_a, sel_b;
    logic [N-1:0]   grant_a, ack_a, grant_b, ack_b;
    logic           busy_a, busy_b, ss_a, ss_b, rb_a, rb_b;
    logic [23:0]    bus_a, bus_b;

    logic [15:0] boff  [N] = '{16'd100, 16'd200, 16'd400, 16'd800};
    logic [15:0] nbase [N] = '{16'h1000, 16'h2000, 16'hA000, 16'h3000};

    rec_t q[$];
    rec_t obs, exp;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        bits_off = '0;
        nw_a     = '0;
        nw_b     = '0;
        for (int k = 0; k < N; k++) begin
            bits_off[16*k +: 16] = boff[k];
            nw_a[16*k +: 16]     = nbase[k] + 16'(sel_a);
            nw_b[16*k +: 16]     = nbase[k] + 16'(sel_b);
        end
    end

    nonce_report_arbiter #(
        .NUM_CORES(N), .CORE_ID_BASE(24'h000000),
        .NONCE_WORDS(8), .HOLD_CYCLES(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .bits_off_i(bits_off), .nonce_word_i(nw_a),
        .nonce_word_sel_o(sel_a), .grant_o(grant_a), .ack_o(ack_a),
        .clear_best_i(clear_best), .busy_o(busy_a), .main_bus_o(bus_a),
        .save_selection_o(ss_a), .reset_best_nonce_o(rb_a)
    );

    nonce_report_arbiter #(
        .NUM_CORES(N), .CORE_ID_BASE(24'hFFFFFE),
        .NONCE_WORDS(8), .HOLD_CYCLES(3)
    ) dut_wrap (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .bits_off_i(bits_off), .nonce_word_i(nw_b),
        .nonce_word_sel_o(sel_b), .grant_o(grant_b), .ack_o(ack_b),
        .clear_best_i(clear_best), .busy_o(busy_b), .main_bus_o(bus_b),
        .save_selection_o(ss_b), .reset_best_nonce_o(rb_b)
    );

    function automatic rec_t sample(input bit w);
        if (w)
            return {ss_b, rb_b, busy_b, bus_b, sel_b, grant_b, ack_b};
        return {ss_a, rb_a, busy_a, bus_a, sel_a, grant_a, ack_a};
    endfunction

    function automatic void push_idle(input int n);
        for (int j = 0; j < n; j++) q.push_back('0);
    endfunction

    function automatic void push_clear();
        rec_t r;
        r = '0;
        r.rb = 1'b1;
        r.busy = 1'b1;
        q.push_back(r);
    endfunction

    // Expected recorder view of the first n cycles of core c's report.
    function automatic void push_report(input int c, input int n,
                                        input logic [23:0] base);
        rec_t r;
        for (int j = 0; j < n; j++) begin
            r = '0;
            r.busy  = 1'b1;
            r.grant = N'(1 << c);
            if (j == 0) begin
                r.ss  = 1'b1;
                r.bus = base + 24'(c);
            end else if (j == 1) begin
                r.bus = {8'd0, boff[c]};
            end else if (j >= 5 && j < 13) begin
                r.sel = 3'(j - 5);
                r.bus = {8'd0, nbase[c] + 16'(j - 5)};
            end else if (j == 13) begin
                r.ack = N'(1 << c);
            end
            q.push_back(r);
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        clear_best = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            obs = sample(0);
            checks++;
            if (obs !== rec_t'(0)) begin
                errors++;
                $display("FAIL reset[%0d] got %h want 0", n, obs);
            end
            obs = sample(1);
            checks++;
            if (obs !== rec_t'(0)) begin
                errors++;
                $display("FAIL reset_wrap[%0d] got %h want 0", n, obs);
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        int n = 0;
        do_reset();
        req[2] = 1'b1;
        push_idle(1);
        push_report(2, 14, 24'h0);
        push_idle(2);
        while (q.size() > 0) begin
            @(negedge clk);
            exp = q.pop_front();
            obs = sample(0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single[%0d] got %h want %h", n, obs, exp);
            end
            if (exp.ack != 0) req = '0;
            n++;
        end
    endtask

    task automatic test_contention();
        int n = 0;
        bit seen0 = 1'b0;
        do_reset();
        req = 4'b1011;
        push_idle(1);
        push_report(0, 14, 24'h0);
        push_idle(1);
        push_report(1, 14, 24'h0);
        push_idle(1);
        push_report(3, 14, 24'h0);
        push_idle(1);
        push_report(0, 14, 24'h0);
        push_idle(2);
        while (q.size() > 0) begin
            @(negedge clk);
            exp = q.pop_front();
            obs = sample(0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL contention[%0d] got %h want %h", n, obs, exp);
            end
            if (exp.ack == 4'b0010 || exp.ack == 4'b1000)
                req = req & ~exp.ack;
            if (exp.ack == 4'b0001) begin
                if (seen0) req[0] = 1'b0;
                seen0 = 1'b1;
            end
            n++;
        end
    endtask

    task automatic test_clear_vs_req();
        int n = 0;
        do_reset();
        clear_best = 1'b1;
        req[1] = 1'b1;
        push_idle(1);
        push_clear();
        push_idle(1);
        push_report(1, 14, 24'h0);
        push_idle(2);
        while (q.size() > 0) begin
            @(negedge clk);
            exp = q.pop_front();
            obs = sample(0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clear_vs_req[%0d] got %h want %h", n, obs, exp);
            end
            if (exp.rb) clear_best = 1'b0;
            if (exp.ack != 0) req = '0;
            n++;
        end
    endtask

    task automatic test_clear_in_transfer();
        int n = 0;
        do_reset();
        req[2] = 1'b1;
        push_idle(1);
        push_report(2, 14, 24'h0);
        push_idle(1);
        push_clear();
        push_idle(3);
        while (q.size() > 0) begin
            @(negedge clk);
            exp = q.pop_front();
            obs = sample(0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clear_xfer[%0d] got %h want %h", n, obs, exp);
            end
            clear_best = (n == 9);
            if (exp.ack != 0) req = '0;
            n++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        req[3] = 1'b1;
        push_idle(1);
        push_report(3, 3, 24'h0);
        push_idle(1);
        push_report(3, 14, 24'h0);
        push_idle(2);
        while (q.size() > 0) begin
            @(negedge clk);
            exp = q.pop_front();
            obs = sample(0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid[%0d] got %h want %h", n, obs, exp);
            end
            rst = (n == 3);
            if (exp.ack != 0) req = '0;
            n++;
        end
    endtask

    task automatic test_id_wrap();
        int n = 0;
        do_reset();
        req[3] = 1'b1;
        push_idle(1);
        push_report(3, 14, 24'hFFFFFE);
        push_idle(1);
        while (q.size() > 0) begin
            @(negedge clk);
            exp = q.pop_front();
            obs = sample(1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL id_wrap[%0d] got %h want %h", n, obs, exp);
            end
            if (exp.ss) begin
                checks++;
                if (obs.bus !== 24'h000001) begin
                    errors++;
                    $display("FAIL id_wrap_value got %h want 000001", obs.bus);
                end
            end
            if (exp.ack != 0) req = '0;
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_clear_vs_req();
        test_clear_in_transfer();
        test_reset_mid();
        test_id_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
